// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets, CAUSE layout
// and MODE encoding.
package irq_pkg;

  localparam logic [3:0] IRQ_ENABLE  = 4'h0;
  localparam logic [3:0] IRQ_MODE    = 4'h4;
  localparam logic [3:0] IRQ_PENDING = 4'h8;
  localparam logic [3:0] IRQ_CAUSE   = 4'hC;

  localparam int CAUSE_VALID_BIT = 31;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

  // irq_id width; a single-channel controller still gets a 1-bit id.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Register-access bus between the core's data port and the interrupt controller.
interface irq_controller_if;

  logic        bus_sel;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one interrupt pin, with a delayed copy used to
// detect a synchronised 0->1 transition.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_async,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Maskable, prioritised interrupt controller: per-channel synchronisers, pending
// latch, register window and a registered request/id toward the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int               N_IRQ       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] RESET_MODE  = {N_IRQ{1'b1}},
  parameter int               ID_W        = id_width(N_IRQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_IRQ-1:0]     irq_in,
  irq_controller_if.slave      bus,
  output logic                 cpu_irq,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 irq_ack
);

  logic [N_IRQ-1:0] level;
  logic [N_IRQ-1:0] rise;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .irq_async (irq_in[g]),
      .level     (level[g]),
      .rise      (rise[g])
    );
  end

  logic [N_IRQ-1:0] enable_q,  enable_d;
  logic [N_IRQ-1:0] mode_q,    mode_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic             cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0]  irq_id_q,  irq_id_d;
  logic [31:0]      rdata_q,   rdata_d;

  logic             wr_en;
  logic             rd_en;
  logic [3:0]       reg_addr;
  logic [N_IRQ-1:0] wdata_n;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] mode_chg;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] active;
  logic             unused_bus;

  assign wr_en      = bus.bus_sel & bus.bus_we;
  assign rd_en      = bus.bus_sel & ~bus.bus_we;
  assign reg_addr   = {bus.bus_addr[3:2], 2'b00};
  assign wdata_n    = bus.bus_wdata[N_IRQ-1:0];
  assign unused_bus = ^{bus.bus_addr[1:0], bus.bus_wdata};

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    mode_chg = '0;
    if (wr_en) begin
      case (reg_addr)
        IRQ_ENABLE:  enable_d = wdata_n;
        IRQ_MODE: begin
          mode_d   = wdata_n;
          mode_chg = mode_q ^ wdata_n;
        end
        IRQ_PENDING: w1c = wdata_n;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_clr = '0;
    if (irq_ack && cpu_irq_q) begin
      ack_clr[irq_id_q] = 1'b1;
    end
  end

  // A rise in the same cycle as a W1C/ack wins so no edge is lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mode_q[i] == MODE_EDGE) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~(w1c[i] | ack_clr[i]));
      end else begin
        pending_d[i] = level[i];
      end
      if (mode_chg[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  assign active = pending_q & enable_q;

  always_comb begin
    cpu_irq_d = |active;
    irq_id_d  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        irq_id_d = ID_W'(i);
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (reg_addr)
        IRQ_ENABLE:  rdata_d[N_IRQ-1:0] = enable_q;
        IRQ_MODE:    rdata_d[N_IRQ-1:0] = mode_q;
        IRQ_PENDING: rdata_d[N_IRQ-1:0] = pending_q;
        IRQ_CAUSE: begin
          rdata_d[CAUSE_VALID_BIT] = cpu_irq_q;
          rdata_d[ID_W-1:0]        = irq_id_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q  <= '0;
      mode_q    <= RESET_MODE;
      pending_q <= '0;
      cpu_irq_q <= 1'b0;
      irq_id_q  <= '0;
      rdata_q   <= '0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      cpu_irq_q <= cpu_irq_d;
      irq_id_q  <= irq_id_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cpu_irq       = cpu_irq_q;
  assign irq_id        = irq_id_q;
  assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomised checks of irq_controller against a sample-history
// reference model.
module tb_irq_controller;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic       irq_ack = 1'b0;
  logic       cpu_irq;
  logic [2:0] irq_id;

  irq_controller_if bus();

  irq_controller #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .bus     (bus),
    .cpu_irq (cpu_irq),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: registers as the spec describes them, plus the last three
  // samples of irq_in. With two sync stages the synchronised level seen at edge t
  // is the pin sampled at edge t-2, and a rise is that sample high while t-3 was low.
  logic [7:0]  m_en, m_mode, m_pend;
  logic        m_cpu;
  logic [2:0]  m_id;
  logic [31:0] m_rdata;
  logic [7:0]  h1, h2, h3;
  logic [7:0]  m_clr, m_chg;

  function automatic logic [2:0] lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [7:0] pend_next(logic [7:0] pend, logic [7:0] mode,
                                           logic [7:0] now, logic [7:0] prev,
                                           logic [7:0] clr, logic [7:0] chg);
    return ((mode & ((now & ~prev) | (pend & ~clr))) | (~mode & now)) & ~chg;
  endfunction

  function automatic logic [31:0] reg_read(logic [1:0] word);
    case (word)
      2'd0:    return {24'h0, m_en};
      2'd1:    return {24'h0, m_mode};
      2'd2:    return {24'h0, m_pend};
      default: return {m_cpu, 28'h0, m_id};
    endcase
  endfunction

  assign m_clr = ((bus.bus_sel && bus.bus_we && bus.bus_addr[3:2] == 2'd2) ? bus.bus_wdata[7:0] : 8'h00)
               | ((irq_ack && m_cpu) ? (8'h01 << m_id) : 8'h00);
  assign m_chg = (bus.bus_sel && bus.bus_we && bus.bus_addr[3:2] == 2'd1) ? (m_mode ^ bus.bus_wdata[7:0]) : 8'h00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en <= 8'h00; m_mode <= 8'hFF; m_pend <= 8'h00;
      m_cpu <= 1'b0; m_id <= 3'd0; m_rdata <= 32'h0;
      h1 <= 8'h00; h2 <= 8'h00; h3 <= 8'h00;
    end else begin
      m_pend <= pend_next(m_pend, m_mode, h2, h3, m_clr, m_chg);
      m_cpu  <= |(m_pend & m_en);
      m_id   <= lowest(m_pend & m_en);
      if (bus.bus_sel && bus.bus_we && bus.bus_addr[3:2] == 2'd0) m_en   <= bus.bus_wdata[7:0];
      if (bus.bus_sel && bus.bus_we && bus.bus_addr[3:2] == 2'd1) m_mode <= bus.bus_wdata[7:0];
      if (bus.bus_sel && !bus.bus_we) m_rdata <= reg_read(bus.bus_addr[3:2]);
      h1 <= irq_in; h2 <= h1; h3 <= h2;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("model_cpu_irq", 32'(cpu_irq), 32'(m_cpu));
      chk("model_irq_id", 32'(irq_id), 32'(m_id));
      chk("model_rdata", bus.bus_rdata, m_rdata);
    end
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
    step(1);
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, output logic [31:0] d);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = a;
    step(1);
    bus.bus_sel = 1'b0;
    d = bus.bus_rdata;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 4'h0; bus.bus_wdata = 32'h0;

    // reset defaults, with pins wiggling while reset is held
    step(2);
    irq_in = 8'hFF;
    step(3);
    irq_in = 8'h00;
    step(1);
    reset_n = 1'b1;
    step(3);
    chk("rst_cpu_irq", 32'(cpu_irq), 32'h0);
    rd(IRQ_ENABLE, d);  chk("rst_enable", d, 32'h0);
    rd(IRQ_MODE, d);    chk("rst_mode", d, 32'hFF);
    rd(IRQ_PENDING, d); chk("rst_pending", d, 32'h0);
    rd(IRQ_CAUSE, d);   chk("rst_cause", d, 32'h0);

    // edge latency and priority
    wr(IRQ_ENABLE, 32'h28);
    irq_in = 8'h28;
    step(3);
    chk("edge_cpu_before", 32'(cpu_irq), 32'h0);
    step(1);
    chk("edge_cpu_k3", 32'(cpu_irq), 32'h1);
    chk("edge_id_k3", 32'(irq_id), 32'd3);
    step(4);
    irq_in = 8'h00;
    rd(IRQ_PENDING, d); chk("edge_pending", d, 32'h28);
    rd(IRQ_CAUSE, d);   chk("edge_cause", d, 32'h8000_0003);
    ack();
    chk("ack1_id_hold", 32'(irq_id), 32'd3);
    step(1);
    chk("ack1_cpu", 32'(cpu_irq), 32'h1);
    chk("ack1_id", 32'(irq_id), 32'd5);
    ack();
    step(1);
    chk("ack2_cpu", 32'(cpu_irq), 32'h0);
    rd(IRQ_PENDING, d); chk("ack2_pending", d, 32'h0);

    // level mode
    wr(IRQ_MODE, 32'h00);
    wr(IRQ_ENABLE, 32'h01);
    irq_in = 8'h01;
    step(4);
    chk("lvl_cpu", 32'(cpu_irq), 32'h1);
    chk("lvl_id", 32'(irq_id), 32'd0);
    wr(IRQ_PENDING, 32'h01);
    step(1);
    chk("lvl_w1c_cpu", 32'(cpu_irq), 32'h1);
    rd(IRQ_PENDING, d); chk("lvl_w1c_pending", d, 32'h01);
    irq_in = 8'h00;
    step(3);
    chk("lvl_drop_k2", 32'(cpu_irq), 32'h1);
    step(1);
    chk("lvl_drop_k3", 32'(cpu_irq), 32'h0);

    // masking keeps pending
    wr(IRQ_MODE, 32'hFF);
    wr(IRQ_ENABLE, 32'h00);
    irq_in = 8'h80;
    step(2);
    irq_in = 8'h00;
    step(4);
    rd(IRQ_PENDING, d); chk("mask_pending", d, 32'h80);
    chk("mask_cpu", 32'(cpu_irq), 32'h0);
    wr(IRQ_ENABLE, 32'h80);
    chk("unmask_cpu_same", 32'(cpu_irq), 32'h0);
    step(1);
    chk("unmask_cpu", 32'(cpu_irq), 32'h1);
    chk("unmask_id", 32'(irq_id), 32'd7);
    wr(IRQ_PENDING, 32'h80);

    // W1C on the same edge as the synchronised rise
    wr(IRQ_ENABLE, 32'h04);
    step(1);
    irq_in = 8'h04;
    step(2);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = IRQ_PENDING; bus.bus_wdata = 32'h04;
    step(1);
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
    rd(IRQ_PENDING, d); chk("collide_pending", d, 32'h04);
    chk("collide_id", 32'(irq_id), 32'd2);
    wr(IRQ_PENDING, 32'h04);
    step(2);
    rd(IRQ_PENDING, d); chk("no_rearm_pending", d, 32'h00);
    irq_in = 8'h00;
    step(3);

    // mode change clears pending
    wr(IRQ_ENABLE, 32'h00);
    irq_in = 8'h10;
    step(2);
    irq_in = 8'h00;
    step(4);
    rd(IRQ_PENDING, d); chk("modechg_before", d, 32'h10);
    wr(IRQ_MODE, 32'hEF);
    rd(IRQ_PENDING, d); chk("modechg_to_level", d, 32'h00);
    irq_in = 8'h10;
    step(4);
    rd(IRQ_PENDING, d); chk("level_held", d, 32'h10);
    wr(IRQ_MODE, 32'hFF);
    rd(IRQ_PENDING, d); chk("modechg_to_edge", d, 32'h00);
    irq_in = 8'h00;
    step(3);

    // reset in the middle of a pending request
    wr(IRQ_ENABLE, 32'h10);
    irq_in = 8'h10;
    step(2);
    irq_in = 8'h00;
    step(4);
    chk("prerst_cpu", 32'(cpu_irq), 32'h1);
    rd(IRQ_PENDING, d); chk("prerst_pending", d, 32'h10);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_cpu", 32'(cpu_irq), 32'h0);
    chk("midrst_id", 32'(irq_id), 32'h0);
    chk("midrst_rdata", bus.bus_rdata, 32'h0);
    step(2);
    reset_n = 1'b1;
    step(2);
    rd(IRQ_PENDING, d); chk("postrst_pending", d, 32'h00);
    rd(IRQ_ENABLE, d);  chk("postrst_enable", d, 32'h00);

    // randomised traffic against the model
    wr(IRQ_MODE, 32'($urandom_range(0, 255)));
    wr(IRQ_ENABLE, 32'($urandom_range(0, 255)));
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        bus.bus_sel   = 1'b1;
        bus.bus_we    = ($urandom_range(0, 2) == 0);
        bus.bus_addr  = 4'($urandom);
        bus.bus_wdata = $urandom;
        if (bus.bus_we && bus.bus_addr[3:2] == 2'd1 && $urandom_range(0, 3) != 0)
          bus.bus_sel = 1'b0;
      end else begin
        bus.bus_sel = 1'b0;
        bus.bus_we  = 1'b0;
      end
      irq_ack = ($urandom_range(0, 4) == 0);
      step(1);
    end
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0; irq_ack = 1'b0; irq_in = 8'h00;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
